dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory target for the single-cycle RV32 core's dmem port: on-chip word-organised RAM answering loads/stores.
//  Applies byte/half/word sizing, load sign/zero extension and store byte lanes.
//  Drives the bidirectional dmem_data bus turnaround.
//  Splits word-crossing misaligned accesses into two beats via a small FSM and a ready (stall) output.
// PARAMETERS
//  DEPTH        1024        RAM size in 32-bit words (power of two)
//  BASE         32'h0       byte address of word 0
//  MISALIGN_EN  1           1: split word-crossing accesses into 2 beats; 0: fault them
// PORTS
//  clk             in     1   clock, rising edge
//  rst             in     1   asynchronous, active-low reset
//  dmem_rd         in     1   load request
//  dmem_wr         in     1   store request
//  dmem_addr       in     32  byte address
//  dmem_size       in     3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  dmem_in_enable  out    1   1 = initiator drives dmem_data (store data)
//  dmem_data       inout  32  store data in / load data out
//  dmem_ready      out    1   access completes this cycle; 0 = initiator must hold request
//  dmem_fault      out    1   access rejected: bad size, out of range, rd&wr, or misaligned with MISALIGN_EN=0
// BEHAVIOUR
//  Reset (rst=0, async):
//   - State=IDLE, beat-1 holding register=0.
//   - dmem_ready=1, dmem_fault=0, dmem_in_enable=0, dmem_data=Z.
//   - RAM contents are not reset.
//  Decode:
//   - off = dmem_addr-BASE; word = off[31:2]; lane = off[1:0].
//   - Out of range if word >= DEPTH; a crossing access is out of range if word+1 >= DEPTH.
//  Bus turnaround:
//   - dmem_in_enable = dmem_wr.
//   - dmem_data driven by this block iff dmem_rd & !dmem_wr; else Z.
//  Aligned / non-crossing access (lane+bytes <= 4), single beat:
//   - Loads: combinational read; dmem_data = extract(lane,size), sign-extended for B/H, zero-extended for BU/HU; ready=1.
//   - Stores: byte lanes {lane..lane+bytes-1} written from dmem_data low bytes at posedge clk; ready=1.
//  Crossing access (H at lane 3, W at lane!=0) with MISALIGN_EN=1; FSM IDLE->SECOND->IDLE:
//   - IDLE: ready=0.
//     - Load: word `word` latched into holding reg at posedge.
//     - Store: low part (bytes lane..3 of word) written at posedge.
//     - Go to SECOND.
//   - SECOND: word+1 read/written.
//     - Load: result = holding-reg bytes lane..3 concatenated (LSB first) with word+1 bytes, then extended.
//     - Store: remaining high bytes of dmem_data written to word+1 low lanes.
//     - ready=1; return to IDLE.
//   - Latency: 2 cycles; non-crossing: 1 cycle (0 wait states).
//   - The initiator holds addr/size/data stable while ready=0.
//   - In SECOND, rd=wr=0 -> back to IDLE, no second write; first half stays written.
//  Faults (combinational, IDLE only; ready=1, no RAM write, load data=0):
//   - size in {011,110,111}.
//   - Out of range.
//   - rd&wr both 1.
//   - Crossing access with MISALIGN_EN=0.
//  Idle (rd=wr=0): ready=1, fault=0, no write, dmem_data Z.
//  Reset in SECOND: abort to IDLE; first-half store bytes remain.
// TESTING
//  1. SW 0xDEADBEEF @0x10 then LW @0x10 -> dmem_data=0xDEADBEEF, ready=1 both cycles, fault=0.
//  2. After 1: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
//  3. SB 0x55 @0x11 -> following LW @0x10 = 0xDEAD55EF (other lanes untouched).
//  4. Misaligned, MISALIGN_EN=1: word4=0x44332211, word5=0x88776655; LW @0x12 -> ready 0 then 1, data=0x66554433.
//     SW 0xA1B2C3D4 @0x13 -> word4=0xD4332211, word5=0x88A1B2C3.
//  5. LW @0x12 with MISALIGN_EN=0, size=3'b011, rd&wr=1, or addr=BASE+4*DEPTH -> fault=1, ready=1, no RAM change.
//  6. Assert rst low during SECOND of SW @0x13 -> state IDLE, ready=1, word5 unchanged, word4 low part written.

Source files
------------

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory target for the single-cycle RV32 core's dmem port. Holds an
// on-chip word-organised RAM and answers byte/half/word loads and stores,
// applying load sign/zero extension and store byte-lane enables. It also
// owns the bidirectional dmem_data turnaround.
//
// Accesses whose bytes cross a word boundary (H at lane 3, W at lane != 0)
// are split into two beats by a two-state FSM. The first beat deasserts
// dmem_ready so the initiator holds its request. With MISALIGN_EN = 0 such
// accesses are faulted instead.
//
// Ports
//   clk             in     rising-edge clock
//   rst             in     asynchronous, active-low reset
//   dmem_rd         in     load request
//   dmem_wr         in     store request
//   dmem_addr[31:0] in     byte address
//   dmem_size[2:0]  in     funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   dmem_in_enable  out    1 = initiator drives dmem_data (store data)
//   dmem_data[31:0] inout  store data in / load data out
//   dmem_ready      out    access completes this cycle (0 = hold request)
//   dmem_fault      out    access rejected (bad size, out of range, rd&wr,
//                          or crossing access with MISALIGN_EN = 0)
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,   // RAM words, power of two
    parameter logic [31:0] BASE        = 32'h0,  // byte address of word 0
    parameter bit          MISALIGN_EN = 1'b1    // 1: split crossings, 0: fault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_rd,
    input  logic        dmem_wr,
    input  logic [31:0] dmem_addr,
    input  logic [2:0]  dmem_size,
    output logic        dmem_in_enable,
    inout  wire  [31:0] dmem_data,
    output logic        dmem_ready,
    output logic        dmem_fault
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_SECOND
    } state_e;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH];

    state_e      state_q, state_d;
    logic [31:0] hold_q,  hold_d;   // first-beat word of a crossing load

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]   off;
    logic [29:0]   word;
    logic [1:0]    lane;
    logic [AW-1:0] lo_idx;
    logic [AW-1:0] hi_idx;
    logic [2:0]    nbytes;
    logic [3:0]    be_base;
    logic          size_bad;
    logic          crossing;
    logic          word_oor;
    logic          next_oor;

    assign off    = dmem_addr - BASE;
    assign word   = off[31:2];
    assign lane   = off[1:0];
    assign lo_idx = word[AW-1:0];
    // Wraps at the top of the RAM; the range check faults that case first.
    assign hi_idx = lo_idx + AW'(1);

    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path leaves it unassigned and a latch is inferred.
        nbytes   = 3'd1;
        be_base  = 4'b0001;
        size_bad = 1'b0;
        case (dmem_size)
            3'b000, 3'b100: begin nbytes = 3'd1; be_base = 4'b0001; end
            3'b001, 3'b101: begin nbytes = 3'd2; be_base = 4'b0011; end
            3'b010:         begin nbytes = 3'd4; be_base = 4'b1111; end
            default:        size_bad = 1'b1;
        endcase
    end

    // lane + bytes > 4 means the access spills into the next word.
    assign crossing = !size_bad && ((3'({1'b0, lane}) + nbytes) > 3'd4);
    assign word_oor = ({2'b00, word} >= 32'(DEPTH));
    assign next_oor = crossing && (({2'b00, word} + 32'd1) >= 32'(DEPTH));

    // ------------------------------------------------------------------
    // Byte-lane alignment over a two-word window {word+1, word}
    // ------------------------------------------------------------------
    logic [7:0]  be8;
    logic [63:0] wdata64;
    logic [31:0] lo_word;
    logic [31:0] hi_word;
    logic [31:0] load_raw;
    logic [31:0] load_ext;

    assign be8     = 8'({4'b0000, be_base}) << lane;
    assign wdata64 = {32'h0, dmem_data} << {lane, 3'b000};

    // In the second beat the low word comes from the holding register.
    assign lo_word  = (state_q == ST_SECOND) ? hold_q : mem[lo_idx];
    assign hi_word  = mem[hi_idx];
    assign load_raw = 32'({hi_word, lo_word} >> {lane, 3'b000});

    always_comb begin
        load_ext = '0;
        case (dmem_size)
            3'b000:  load_ext = {{24{load_raw[7]}},  load_raw[7:0]};
            3'b100:  load_ext = {24'h0,              load_raw[7:0]};
            3'b001:  load_ext = {{16{load_raw[15]}}, load_raw[15:0]};
            3'b101:  load_ext = {16'h0,              load_raw[15:0]};
            3'b010:  load_ext = load_raw;
            default: load_ext = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Access control
    // ------------------------------------------------------------------
    logic          req;
    logic          ready_c;
    logic          fault_c;
    logic [31:0]   load_val;
    logic          we_c;
    logic [AW-1:0] waddr;
    logic [3:0]    wbe;
    logic [31:0]   wdat;

    assign req = dmem_rd | dmem_wr;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        ready_c  = 1'b1;
        fault_c  = 1'b0;
        load_val = '0;
        we_c     = 1'b0;
        waddr    = lo_idx;
        wbe      = be8[3:0];
        wdat     = wdata64[31:0];

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (size_bad || word_oor || next_oor ||
                        (dmem_rd && dmem_wr) || (crossing && !MISALIGN_EN)) begin
                        fault_c = 1'b1;
                    end else if (crossing) begin
                        // First beat: low part of the word now, rest next cycle.
                        ready_c = 1'b0;
                        state_d = ST_SECOND;
                        if (dmem_rd) hold_d = mem[lo_idx];
                        we_c    = dmem_wr;
                    end else begin
                        load_val = load_ext;
                        we_c     = dmem_wr;
                    end
                end
            end

            ST_SECOND: begin
                // Request dropped mid-access: abandon it; first half stays.
                state_d = ST_IDLE;
                if (req) begin
                    load_val = load_ext;
                    we_c     = dmem_wr;
                    waddr    = hi_idx;
                    wbe      = be8[7:4];
                    wdat     = wdata64[63:32];
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (forced to their idle values while reset is held)
    // ------------------------------------------------------------------
    logic drive_en;

    assign drive_en       = rst & dmem_rd & ~dmem_wr;
    assign dmem_data      = drive_en ? load_val : 'z;
    assign dmem_in_enable = rst & dmem_wr;
    assign dmem_ready     = ~rst | ready_c;
    assign dmem_fault     = rst & fault_c;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block memory; its
    // contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we_c && rst) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe[b]) mem[waddr][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end

endmodule
